// File: rtl/cpu_mem.sv
//==============================================================================
// Module   : cpu_mem
// Brief    : Multi-read-port, single-write-port synchronous RAM with byte
//            enables, registered reads and a post-reset clear sequencer.
//            Optional macro CPU_MEM_FWD_EN selects write-first forwarding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_mem #(
    parameter int              DATA_W     = 16,
    parameter int              ADDR_W     = 15,
    parameter int              NRD        = 2,
    parameter int              INIT_CLEAR = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD-1:0]          ren,
    input  logic [NRD*ADDR_W-1:0]   raddr,
    output logic [NRD*DATA_W-1:0]   rdata,
    output logic [NRD-1:0]          rvalid,
    input  logic                    wen,
    input  logic [DATA_W/8-1:0]     wbe,
    input  logic [ADDR_W-1:0]       waddr,
    input  logic [DATA_W-1:0]       wdata,
    output logic                    busy
);

    localparam int          c_NBYTE    = DATA_W / 8;
    localparam int          c_DEPTH    = 1 << ADDR_W;
    localparam logic [0:0]  c_st_clear = 1'b0;
    localparam logic [0:0]  c_st_ready = 1'b1;

    logic [DATA_W-1:0]  r_mem [c_DEPTH];
    logic [0:0]         r_state;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic [DATA_W-1:0]  r_rdata [NRD];
    logic [NRD-1:0]     r_rvalid;

    logic               w_ready;
    logic               w_clr_we;
    logic               w_wr_we;
    logic [ADDR_W-1:0]  w_raddr   [NRD];
    logic [DATA_W-1:0]  w_rd_word [NRD];

    assign w_ready  = (r_state == c_st_ready);
    // Reset must never touch the array, hence the explicit rst qualifier.
    assign w_clr_we = (r_state == c_st_clear) && !rst;
    assign w_wr_we  = w_ready && wen && !rst;
    assign busy     = (r_state == c_st_clear);
    assign rvalid   = r_rvalid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= (INIT_CLEAR != 0) ? c_st_clear : c_st_ready;
            r_clr_addr <= '0;
        end else if (r_state == c_st_clear) begin
            r_clr_addr <= r_clr_addr + 1'b1;
            if (r_clr_addr == {ADDR_W{1'b1}}) begin
                r_state <= c_st_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_clr_addr] <= CLEAR_VAL;
        end else if (w_wr_we) begin
            for (int b = 0; b < c_NBYTE; b++) begin
                if (wbe[b]) begin
                    r_mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

`ifdef CPU_MEM_FWD_EN
    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [c_NBYTE-1:0] be);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < c_NBYTE; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction
`endif

    generate
        for (genvar k = 0; k < NRD; k++) begin : g_port
            assign w_raddr[k] = raddr[k*ADDR_W +: ADDR_W];
`ifdef CPU_MEM_FWD_EN
            // Write-first: a same-edge write to this address is merged bytewise.
            assign w_rd_word[k] = (w_wr_we && (waddr == w_raddr[k]))
                                ? f_merge(r_mem[w_raddr[k]], wdata, wbe)
                                : r_mem[w_raddr[k]];
`else
            assign w_rd_word[k] = r_mem[w_raddr[k]];
`endif
            assign rdata[k*DATA_W +: DATA_W] = r_rdata[k];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= '0;
            for (int k = 0; k < NRD; k++) begin
                r_rdata[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NRD; k++) begin
                r_rvalid[k] <= w_ready && ren[k];
                if (w_ready && ren[k]) begin
                    r_rdata[k] <= w_rd_word[k];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_mem.sv
//==============================================================================
// Module   : tb_cpu_mem
// Brief    : Scoreboard bench for cpu_mem (ADDR_W=4, NRD=2, CLEAR_VAL=A5A5).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_mem;

    localparam int DW = 16;
    localparam int AW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     ren;
    logic [2*AW-1:0] raddr;
    logic [2*DW-1:0] rdata;
    logic [1:0]     rvalid;
    logic           wen;
    logic [1:0]     wbe;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    cpu_mem #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .NRD       (2),
        .INIT_CLEAR(1),
        .CLEAR_VAL (16'hA5A5)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata),
        .rvalid(rvalid),
        .wen   (wen),
        .wbe   (wbe),
        .waddr (waddr),
        .wdata (wdata),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented read result is matched against the scoreboard.
    always @(negedge clk) begin
        if (rvalid[0] === 1'b1) begin
            if (q0.size() == 0) begin
                check("p0_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check("p0_rdata", {16'h0, rdata[DW-1:0]}, {16'h0, q0.pop_front()});
            end
        end
        if (rvalid[1] === 1'b1) begin
            if (q1.size() == 0) begin
                check("p1_unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                check("p1_rdata", {16'h0, rdata[2*DW-1:DW]}, {16'h0, q1.pop_front()});
            end
        end
    end

    task automatic cyc(input logic we, input logic [1:0] be, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [1:0] re,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        wen   = we;
        wbe   = be;
        waddr = wa;
        wdata = wd;
        ren   = re;
        raddr = {ra1, ra0};
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 2'b00;
    endtask

    initial begin
        int n;
        logic [DW-1:0] exp_fwd;
        rst = 1'b1; wen = 1'b0; ren = 2'b00; wbe = 2'b00;
        waddr = '0; wdata = '0; raddr = '0;

        @(posedge clk);
        @(negedge clk);
        check("reset_busy",   {31'h0, busy}, 32'd1);
        check("reset_rvalid", {30'h0, rvalid}, 32'd0);
        check("reset_rdata",  rdata, 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("busy_in_reset", {31'h0, busy}, 32'd1);
        rst = 1'b0;

        // Requests during clear must be ignored.
        wen = 1'b1; wbe = 2'b11; waddr = 4'd2; wdata = 16'h1111;
        ren = 2'b11; raddr = {4'd2, 4'd2};
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        wen = 1'b0; ren = 2'b00;
        check("clear_cycles", n, 32'd16);

        for (int i = 0; i < 16; i++) begin
            q0.push_back(16'hA5A5);
            q1.push_back(16'hA5A5);
            cyc(1'b0, 2'b00, 4'd0, 16'h0, 2'b11, 4'(i), 4'(15 - i));
        end

        cyc(1'b1, 2'b11, 4'd3, 16'h1234, 2'b00, 4'd0, 4'd0);
        cyc(1'b1, 2'b10, 4'd3, 16'hFF00, 2'b00, 4'd0, 4'd0);
        q0.push_back(16'hFF34);
        q1.push_back(16'hFF34);
        cyc(1'b0, 2'b00, 4'd0, 16'h0, 2'b11, 4'd3, 4'd3);
        cyc(1'b0, 2'b00, 4'd0, 16'h0, 2'b00, 4'd7, 4'd8);
        check("idle_rvalid", {30'h0, rvalid}, 32'd0);
        check("hold_rdata",  rdata, 32'hFF34FF34);

`ifdef CPU_MEM_FWD_EN
        exp_fwd = 16'h00BB;
`else
        exp_fwd = 16'h0001;
`endif
        cyc(1'b1, 2'b11, 4'd5, 16'h0001, 2'b00, 4'd0, 4'd0);
        q0.push_back(exp_fwd);
        cyc(1'b1, 2'b01, 4'd5, 16'h00BB, 2'b01, 4'd5, 4'd0);
        q0.push_back(16'h00BB);
        cyc(1'b0, 2'b00, 4'd0, 16'h0, 2'b01, 4'd5, 4'd0);

`ifdef CPU_MEM_FWD_EN
        exp_fwd = 16'hFF77;
`else
        exp_fwd = 16'hFF34;
`endif
        q0.push_back(16'hA5A5);
        q1.push_back(exp_fwd);
        cyc(1'b1, 2'b01, 4'd3, 16'h0077, 2'b11, 4'd4, 4'd3);
        q0.push_back(16'hFF77);
        q1.push_back(16'hA5A5);
        cyc(1'b0, 2'b00, 4'd0, 16'h0, 2'b11, 4'd3, 4'd2);

        repeat (3) @(posedge clk);
        #1;
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
